// File: rtl/lcd_line_scheduler_pkg.sv
// Shared types and constants for the two-line HD44780 refresh scheduler.
package lcd_sched_pkg;

  localparam int NUM_LINES      = 2;
  localparam int CHARS_PER_LINE = 16;
  localparam int INIT_LEN       = 4;

  localparam logic [7:0] CMD_CLEAR = 8'h01;

  typedef enum logic [2:0] {POR_WAIT, INIT, IDLE, ADDR, CHARS} sched_state_t;
  typedef enum logic [1:0] {W_IDLE, W_SETUP, W_PULSE, W_HOLD} wr_state_t;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
    logic       long_wait;
  } wr_req_t;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return CMD_CLEAR;
      default: return 8'h06;
    endcase
  endfunction

  function automatic logic [7:0] line_addr(input logic line);
    return line ? 8'hC0 : 8'h80;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_line_scheduler_if.sv
// Requester-side bus: level requests, done pulses and the character fetch port.
interface lcd_line_scheduler_if;
  import lcd_sched_pkg::*;

  logic [NUM_LINES-1:0] req;
  logic [NUM_LINES-1:0] done;
  logic                 char_line;
  logic [3:0]           char_idx;
  logic [7:0]           char_data;

  modport master (output req, char_data, input done, char_line, char_idx);
  modport slave  (input req, char_data, output done, char_line, char_idx);
endinterface

// File: rtl/lcd_line_scheduler_byte_writer.sv
// One LCD bus write: SETUP (RS/DATA settle), PULSE (EN high), HOLD (busy wait).
module lcd_byte_writer
  import lcd_sched_pkg::*;
#(
  parameter int SETUP_CYC    = 4,
  parameter int EN_CYC       = 16,
  parameter int WAIT_CYC     = 2000,
  parameter int CLR_WAIT_CYC = 82000,
  parameter int CNT_W        = 23
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       rs,
  input  logic [7:0] data,
  input  logic       long_wait,
  output logic       complete,
  output logic       lcd_en,
  output logic       lcd_rs,
  output logic [7:0] lcd_data
);

  wr_state_t        st, st_nxt;
  logic [CNT_W-1:0] cnt, term;
  logic             cnt_done, long_q;

  always_comb begin
    st_nxt   = st;
    term     = '0;
    case (st)
      W_SETUP: term = CNT_W'(SETUP_CYC - 1);
      W_PULSE: term = CNT_W'(EN_CYC - 1);
      W_HOLD:  term = long_q ? CNT_W'(CLR_WAIT_CYC - 1) : CNT_W'(WAIT_CYC - 1);
      default: term = '0;
    endcase
    cnt_done = (cnt == term);
    case (st)
      W_IDLE:  if (start)    st_nxt = W_SETUP;
      W_SETUP: if (cnt_done) st_nxt = W_PULSE;
      W_PULSE: if (cnt_done) st_nxt = W_HOLD;
      W_HOLD:  if (cnt_done) st_nxt = W_IDLE;
      default:               st_nxt = W_IDLE;
    endcase
    lcd_en   = (st == W_PULSE);
    complete = (st == W_HOLD) && cnt_done;
  end

  always_ff @(posedge clock) begin
    if (reset) st <= W_IDLE;
    else       st <= st_nxt;
  end

  // RS/DATA are captured once at start and stay put through the whole HOLD.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt      <= '0;
      long_q   <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_data <= '0;
    end else begin
      if (st_nxt != st)     cnt <= '0;
      else if (st != W_IDLE) cnt <= cnt + CNT_W'(1);
      if (st == W_IDLE && start) begin
        lcd_rs   <= rs;
        lcd_data <= data;
        long_q   <= long_wait;
      end
    end
  end

endmodule

// File: rtl/lcd_line_scheduler.sv
// HD44780 16x2 bus owner: power-on init, then round-robin full-line refreshes.
// Build option LCD_AUTO_REFRESH_EN adds a periodic refresh request for both lines.
module lcd_line_scheduler
  import lcd_sched_pkg::*;
#(
  parameter int PWRUP_CYC    = 750000,
  parameter int SETUP_CYC    = 4,
  parameter int EN_CYC       = 16,
  parameter int WAIT_CYC     = 2000,
  parameter int CLR_WAIT_CYC = 82000,
  parameter int REFRESH_CYC  = 5000000
) (
  input  logic                       clock,
  input  logic                       reset,
  lcd_line_scheduler_if.slave        bus,
  output logic [7:0]                 LCD_DATA,
  output logic                       LCD_RS,
  output logic                       LCD_RW,
  output logic                       LCD_EN,
  output logic                       init_done,
  output logic                       busy
);

  localparam int CNT_W = $clog2(max2(max2(max2(PWRUP_CYC, CLR_WAIT_CYC), REFRESH_CYC),
                                     max2(max2(WAIT_CYC, EN_CYC), SETUP_CYC)) + 1);

  sched_state_t         state, state_nxt;
  logic [CNT_W-1:0]     por_cnt;
  logic [1:0]           init_idx;
  logic [3:0]           idx;
  logic                 line_q, rr_last, wr_active;
  logic                 wr_start, wr_complete, gnt_valid, gnt_line;
  logic                 last_init, last_char, line_done;
  logic [NUM_LINES-1:0] eff_req;
  wr_req_t              wr_req;

`ifdef LCD_AUTO_REFRESH_EN
  logic [CNT_W-1:0]     ref_cnt;
  logic [NUM_LINES-1:0] pending;
  logic                 ref_wrap;

  assign ref_wrap = init_done && (ref_cnt == CNT_W'(REFRESH_CYC - 1));

  // Cleared on the completing edge so IDLE never re-grants a just-finished line.
  always_ff @(posedge clock) begin
    if (reset) begin
      ref_cnt <= '0;
      pending <= '0;
    end else begin
      if (init_done) ref_cnt <= ref_wrap ? '0 : ref_cnt + CNT_W'(1);
      pending <= (pending & ~(line_done ? (2'b01 << line_q) : 2'b00)) | {NUM_LINES{ref_wrap}};
    end
  end

  assign eff_req = bus.req | pending;
`else
  assign eff_req = bus.req;
`endif

  assign gnt_valid = |eff_req;
  assign gnt_line  = (&eff_req) ? ~rr_last : eff_req[1];
  assign last_init = (init_idx == 2'(INIT_LEN - 1));
  assign last_char = (idx == 4'(CHARS_PER_LINE - 1));
  assign line_done = (state == CHARS) && wr_complete && last_char;

  always_comb begin
    state_nxt = state;
    wr_start  = 1'b0;
    wr_req    = '0;
    case (state)
      POR_WAIT: if (por_cnt == CNT_W'(PWRUP_CYC - 1)) state_nxt = INIT;
      INIT: begin
        wr_start         = !wr_active;
        wr_req.data      = init_cmd(init_idx);
        wr_req.long_wait = (wr_req.data == CMD_CLEAR);
        if (wr_complete && last_init) state_nxt = IDLE;
      end
      IDLE: if (gnt_valid) state_nxt = ADDR;
      ADDR: begin
        wr_start    = !wr_active;
        wr_req.data = line_addr(line_q);
        if (wr_complete) state_nxt = CHARS;
      end
      CHARS: begin
        wr_start    = !wr_active;
        wr_req.rs   = 1'b1;
        wr_req.data = bus.char_data;
        if (line_done) state_nxt = IDLE;
      end
      default: state_nxt = POR_WAIT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= POR_WAIT;
    else       state <= state_nxt;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      por_cnt   <= '0;
      init_idx  <= '0;
      idx       <= '0;
      line_q    <= 1'b0;
      rr_last   <= 1'b1;
      wr_active <= 1'b0;
      init_done <= 1'b0;
      bus.done  <= '0;
      busy      <= 1'b0;
    end else begin
      if (state == POR_WAIT) por_cnt <= por_cnt + CNT_W'(1);
      if (wr_start)         wr_active <= 1'b1;
      else if (wr_complete) wr_active <= 1'b0;
      if (state == INIT && wr_complete) begin
        init_idx <= init_idx + 2'd1;
        if (last_init) init_done <= 1'b1;
      end
      if (state == IDLE && gnt_valid) begin
        line_q  <= gnt_line;
        rr_last <= gnt_line;
      end
      if (state == CHARS && wr_complete) idx <= last_char ? 4'd0 : idx + 4'd1;
      bus.done <= line_done ? (2'b01 << line_q) : 2'b00;
      busy     <= (state_nxt != IDLE);
    end
  end

  assign bus.char_line = line_q;
  assign bus.char_idx  = idx;
  assign LCD_RW        = 1'b0;

  lcd_byte_writer #(
    .SETUP_CYC    (SETUP_CYC),
    .EN_CYC       (EN_CYC),
    .WAIT_CYC     (WAIT_CYC),
    .CLR_WAIT_CYC (CLR_WAIT_CYC),
    .CNT_W        (CNT_W)
  ) u_writer (
    .clock     (clock),
    .reset     (reset),
    .start     (wr_start),
    .rs        (wr_req.rs),
    .data      (wr_req.data),
    .long_wait (wr_req.long_wait),
    .complete  (wr_complete),
    .lcd_en    (LCD_EN),
    .lcd_rs    (LCD_RS),
    .lcd_data  (LCD_DATA)
  );

endmodule

// File: tb/tb_lcd_line_scheduler.sv
// Scoreboard bench for lcd_line_scheduler with scaled-down timing.
module tb_lcd_line_scheduler;

  localparam int PWRUP = 20, SETUP = 2, ENW = 3, WAITC = 5, CLRW = 12, REFR = 200;
  localparam logic [127:0] L0 = "0123456789ABCDEF";
  localparam logic [127:0] L1 = "ghijklmnopqrstuv";

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #10 clock = ~clock;

  lcd_line_scheduler_if bus();
  logic [7:0] LCD_DATA;
  logic       LCD_RS, LCD_RW, LCD_EN, init_done, busy;

  lcd_line_scheduler #(
    .PWRUP_CYC(PWRUP), .SETUP_CYC(SETUP), .EN_CYC(ENW),
    .WAIT_CYC(WAITC), .CLR_WAIT_CYC(CLRW), .REFRESH_CYC(REFR)
  ) dut (
    .clock(clock), .reset(reset), .bus(bus),
    .LCD_DATA(LCD_DATA), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_EN(LCD_EN),
    .init_done(init_done), .busy(busy)
  );

  function automatic logic [7:0] char_at(input logic ln, input logic [3:0] i);
    logic [127:0] s;
    s = ln ? L1 : L0;
    return s[8*(15-i) +: 8];
  endfunction

  assign bus.char_data = char_at(bus.char_line, bus.char_idx);

  int         total = 0, bad = 0, rises = 0;
  bit         mon_on = 1'b1;
  logic [8:0] exp_q[$];
  logic [1:0] done_q[$];
  int         gap_q[$];

  // Monitor: pops the expected {RS,DATA} at every EN rise, checks stability and widths.
  initial begin : mon
    logic       en_prev;
    logic [1:0] done_prev;
    logic [8:0] cur, e;
    int         w, low;
    bit         have_fall;
    en_prev = 1'b0; done_prev = 2'b00; cur = '0; w = 0; low = 0; have_fall = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        en_prev = 1'b0; done_prev = 2'b00; w = 0; low = 0; have_fall = 1'b0;
      end else begin
        if (LCD_EN && !en_prev) begin
          rises++;
          cur = {LCD_RS, LCD_DATA};
          w = 1;
          if (have_fall) gap_q.push_back(low);
          if (mon_on) begin
            total++;
            if (exp_q.size() == 0) begin
              bad++;
              $display("FAIL byte: got rs=%0d data=%02h, expected none", LCD_RS, LCD_DATA);
            end else begin
              e = exp_q.pop_front();
              if (cur !== e)
                begin bad++; $display("FAIL byte: got %03h expected %03h", cur, e); end
            end
          end
        end else if (LCD_EN) begin
          w++;
          total++;
          if ({LCD_RS, LCD_DATA} !== cur)
            begin bad++; $display("FAIL bus_stable: got %03h expected %03h", {LCD_RS, LCD_DATA}, cur); end
        end else if (en_prev) begin
          have_fall = 1'b1;
          low = 1;
          total++;
          if (w !== ENW) begin bad++; $display("FAIL en_width: got %0d expected %0d", w, ENW); end
        end else begin
          low++;
        end
        if (bus.done !== 2'b00) begin
          done_q.push_back(bus.done);
          total++;
          if (done_prev !== 2'b00)
            begin bad++; $display("FAIL done_width: done=%b also high previous cycle", bus.done); end
        end
        en_prev = LCD_EN;
        done_prev = bus.done;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_init;
    exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h0C});
    exp_q.push_back({1'b0, 8'h01});
    exp_q.push_back({1'b0, 8'h06});
  endtask

  task automatic push_line(input logic ln, input int nchars);
    exp_q.push_back({1'b0, ln ? 8'hC0 : 8'h80});
    for (int i = 0; i < nchars; i++) exp_q.push_back({1'b1, char_at(ln, 4'(i))});
  endtask

  task automatic wait_done(input int n, input int budget, output bit ok);
    int seen;
    seen = 0; ok = 1'b0;
    for (int t = 0; t < budget; t++) begin
      @(negedge clock);
      if (bus.done !== 2'b00) begin
        seen++;
        if (seen == n) begin ok = 1'b1; break; end
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.req = 2'b00;
    repeat (3) @(negedge clock);
    total++;
    if ({LCD_EN, LCD_RS, LCD_RW, LCD_DATA} !== 11'd0)
      begin bad++; $display("FAIL reset_pins: got %03h expected 000", {LCD_EN, LCD_RS, LCD_RW, LCD_DATA}); end
    total++;
    if ({init_done, busy} !== 2'b00)
      begin bad++; $display("FAIL reset_status: got %b expected 00", {init_done, busy}); end
    total++;
    if ({bus.done, bus.char_line, bus.char_idx} !== 7'd0)
      begin bad++; $display("FAIL reset_bus: got %h expected 0", {bus.done, bus.char_line, bus.char_idx}); end
  endtask

  task automatic test_init;
    int first, base, n;
    exp_q.delete(); gap_q.delete();
    push_init();
    base = rises;
    reset = 1'b0;
    first = -1;
    for (int t = 0; t < 100; t++) begin
      @(negedge clock);
      if (LCD_EN) begin first = t; break; end
    end
    total++;
    if (first < PWRUP || first > PWRUP + SETUP + 2)
      begin bad++; $display("FAIL por_wait: first EN after %0d cycles, expected %0d..%0d", first, PWRUP, PWRUP + SETUP + 2); end
    for (int t = 0; t < 200 && rises < base + 4; t++) @(negedge clock);
    for (int t = 0; t < 20 && LCD_EN; t++) @(negedge clock);
    total++;
    if (rises !== base + 4 || init_done !== 1'b0)
      begin bad++; $display("FAIL init_cmds: %0d pulses init_done=%b, expected 4 and 0", rises - base, init_done); end
    n = 0;
    while (!init_done && n < 50) begin n++; @(negedge clock); end
    total++;
    if (n !== WAITC) begin bad++; $display("FAIL init_done_rise: after %0d low cycles expected %0d", n, WAITC); end
    total++;
    if (exp_q.size() !== 0) begin bad++; $display("FAIL init_sb: %0d bytes left expected 0", exp_q.size()); end
    total++;
    if (gap_q.size() < 3 || gap_q[0] !== gap_q[1] || gap_q[2] - gap_q[1] !== CLRW - WAITC || gap_q[1] < WAITC + SETUP)
      begin bad++; $display("FAIL init_gaps: got %p expected equal normal gaps and clear gap +%0d", gap_q, CLRW - WAITC); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_both;
    bit ok;
    done_q.delete();
    push_line(1'b0, 16); push_line(1'b1, 16); push_line(1'b0, 16);
    bus.req = 2'b11;
    wait_done(3, 2000, ok);
    bus.req = 2'b00;
    @(negedge clock);
    total++;
    if (!ok) begin bad++; $display("FAIL both_timeout: 3 done pulses not seen"); end
    total++;
    if (done_q.size() !== 3 || done_q[0] !== 2'b01 || done_q[1] !== 2'b10 || done_q[2] !== 2'b01)
      begin bad++; $display("FAIL both_order: got %p expected 01,10,01", done_q); end
    repeat (50) @(negedge clock);
    total++;
    if (exp_q.size() !== 0 || busy !== 1'b0)
      begin bad++; $display("FAIL both_end: %0d bytes left busy=%b expected 0/0", exp_q.size(), busy); end
  endtask

  task automatic test_single;
    bit ok;
    int base;
    done_q.delete();
    base = rises;
    push_line(1'b0, 16);
    bus.req = 2'b01;
    wait_done(1, 1000, ok);
    bus.req = 2'b00;
    repeat (40) @(negedge clock);
    total++;
    if (!ok || done_q.size() !== 1 || done_q[0] !== 2'b01)
      begin bad++; $display("FAIL single_done: got %p expected 01", done_q); end
    total++;
    if (rises - base !== 17 || exp_q.size() !== 0)
      begin bad++; $display("FAIL single_bytes: got %0d pulses expected 17", rises - base); end
  endtask

  task automatic test_mid_switch;
    bit ok;
    done_q.delete();
    push_line(1'b0, 16); push_line(1'b1, 16);
    bus.req = 2'b01;
    for (int t = 0; t < 500 && bus.char_idx != 4'd5; t++) @(negedge clock);
    bus.req = 2'b10;
    wait_done(2, 1500, ok);
    bus.req = 2'b00;
    repeat (40) @(negedge clock);
    total++;
    if (!ok || done_q.size() !== 2 || done_q[0] !== 2'b01 || done_q[1] !== 2'b10)
      begin bad++; $display("FAIL mid_switch: got %p expected 01,10", done_q); end
    total++;
    if (exp_q.size() !== 0) begin bad++; $display("FAIL mid_sb: %0d bytes left expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid;
    int base;
    exp_q.delete();
    push_line(1'b0, 8);
    base = rises;
    bus.req = 2'b01;
    for (int t = 0; t < 500 && rises < base + 9; t++) @(negedge clock);
    total++;
    if (LCD_EN !== 1'b1 || bus.char_idx !== 4'd7)
      begin bad++; $display("FAIL reset_mid_pos: en=%b idx=%0d expected 1/7", LCD_EN, bus.char_idx); end
    reset = 1'b1;
    bus.req = 2'b00;
    @(negedge clock);
    total++;
    if (LCD_EN !== 1'b0 || init_done !== 1'b0)
      begin bad++; $display("FAIL reset_mid_en: en=%b init_done=%b expected 0/0", LCD_EN, init_done); end
    total++;
    if (exp_q.size() !== 0) begin bad++; $display("FAIL reset_mid_sb: %0d bytes left expected 0", exp_q.size()); end
    repeat (2) @(negedge clock);
    exp_q.delete();
    push_init();
    base = rises;
    reset = 1'b0;
    for (int t = 0; t < 300 && !init_done; t++) @(negedge clock);
    total++;
    if (init_done !== 1'b1 || rises - base !== 4 || exp_q.size() !== 0)
      begin bad++; $display("FAIL reinit: init_done=%b pulses=%0d expected 1/4", init_done, rises - base); end
  endtask

`ifdef LCD_AUTO_REFRESH_EN
  task automatic test_auto_refresh;
    bit ok;
    done_q.delete();
    exp_q.delete();
    push_line(1'b0, 16); push_line(1'b1, 16);
    bus.req = 2'b00;
    wait_done(2, 1500, ok);
    mon_on = 1'b0;
    @(negedge clock);
    total++;
    if (!ok || done_q.size() < 2 || done_q[0] !== 2'b01 || done_q[1] !== 2'b10)
      begin bad++; $display("FAIL auto_refresh: got %p expected 01,10", done_q); end
    total++;
    if (exp_q.size() !== 0) begin bad++; $display("FAIL auto_sb: %0d bytes left expected 0", exp_q.size()); end
  endtask
`endif

  initial begin
    bus.req = 2'b00;
    test_reset();
    test_init();
    test_both();
    test_single();
    test_mid_switch();
    test_reset_mid();
`ifdef LCD_AUTO_REFRESH_EN
    test_auto_refresh();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
